// File: rtl/ctrl_pipe_carrier.sv
// Control-path pipeline registers ID/EX -> EX/MEM -> MEM/WB for the decode
// interface, with load-use stall detection, flush bubbles and halt freeze.
module ctrl_pipe_carrier #(
  parameter int NB_REG = 5,
  parameter int REG_RA = 31
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_halt,
  input  logic              i_flush,
  input  logic              i_id_jump,
  input  logic [1:0]        i_id_aluSrc,
  input  logic [1:0]        i_id_aluOp,
  input  logic              i_id_branch,
  input  logic              i_id_regDst,
  input  logic              i_id_mem2Reg,
  input  logic              i_id_regWrite,
  input  logic              i_id_memRead,
  input  logic              i_id_memWrite,
  input  logic [1:0]        i_id_width,
  input  logic              i_id_sign_flag,
  input  logic              i_id_immediate,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic [NB_REG-1:0] i_id_rd,
  output logic              o_stall,
  output logic              o_ex_jump,
  output logic [1:0]        o_ex_aluSrc,
  output logic [1:0]        o_ex_aluOp,
  output logic              o_ex_branch,
  output logic              o_ex_immediate,
  output logic [NB_REG-1:0] o_ex_dest,
  output logic              o_mem_memRead,
  output logic              o_mem_memWrite,
  output logic [1:0]        o_mem_width,
  output logic              o_mem_sign_flag,
  output logic              o_mem_regWrite,
  output logic              o_mem_mem2Reg,
  output logic [NB_REG-1:0] o_mem_dest,
  output logic              o_wb_regWrite,
  output logic              o_wb_mem2Reg,
  output logic [NB_REG-1:0] o_wb_dest
);

  typedef struct packed {
    logic              jump;
    logic [1:0]        aluSrc;
    logic [1:0]        aluOp;
    logic              branch;
    logic              immediate;
    logic              memRead;
    logic              memWrite;
    logic [1:0]        width;
    logic              sign_flag;
    logic              regWrite;
    logic              mem2Reg;
    logic [NB_REG-1:0] dest;
  } idex_t;

  typedef struct packed {
    logic              memRead;
    logic              memWrite;
    logic [1:0]        width;
    logic              sign_flag;
    logic              regWrite;
    logic              mem2Reg;
    logic [NB_REG-1:0] dest;
  } exmem_t;

  typedef struct packed {
    logic              regWrite;
    logic              mem2Reg;
    logic [NB_REG-1:0] dest;
  } memwb_t;

  localparam logic [NB_REG-1:0] RA = NB_REG'(REG_RA);

  idex_t             r_ex;
  exmem_t            r_mem;
  memwb_t            r_wb;
  idex_t             w_id;
  logic [NB_REG-1:0] w_dest;
  logic              w_haz;

  always_comb begin
    if (i_id_jump && i_id_regWrite && !i_id_regDst) w_dest = RA;
    else if (i_id_regDst)                           w_dest = i_id_rd;
    else                                            w_dest = i_id_rt;
  end

  // A write to $zero is dropped here so later stages never see it.
  always_comb begin
    w_id           = '0;
    w_id.jump      = i_id_jump;
    w_id.aluSrc    = i_id_aluSrc;
    w_id.aluOp     = i_id_aluOp;
    w_id.branch    = i_id_branch;
    w_id.immediate = i_id_immediate;
    w_id.memRead   = i_id_memRead;
    w_id.memWrite  = i_id_memWrite;
    w_id.width     = i_id_width;
    w_id.sign_flag = i_id_sign_flag;
    w_id.regWrite  = i_id_regWrite && (w_dest != '0);
    w_id.mem2Reg   = i_id_mem2Reg;
    w_id.dest      = w_dest;
  end

  assign w_haz = r_ex.memRead && r_ex.regWrite && (r_ex.dest != '0) &&
                 ((r_ex.dest == i_id_rs) || (r_ex.dest == i_id_rt));

  assign o_stall = i_reset && (w_haz || i_halt);

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!i_halt) begin
      r_ex           <= (i_flush || w_haz) ? '0 : w_id;
      r_mem.memRead   <= r_ex.memRead;
      r_mem.memWrite  <= r_ex.memWrite;
      r_mem.width     <= r_ex.width;
      r_mem.sign_flag <= r_ex.sign_flag;
      r_mem.regWrite  <= r_ex.regWrite;
      r_mem.mem2Reg   <= r_ex.mem2Reg;
      r_mem.dest      <= r_ex.dest;
      r_wb.regWrite   <= r_mem.regWrite;
      r_wb.mem2Reg    <= r_mem.mem2Reg;
      r_wb.dest       <= r_mem.dest;
    end
  end

  assign o_ex_jump       = r_ex.jump;
  assign o_ex_aluSrc     = r_ex.aluSrc;
  assign o_ex_aluOp      = r_ex.aluOp;
  assign o_ex_branch     = r_ex.branch;
  assign o_ex_immediate  = r_ex.immediate;
  assign o_ex_dest       = r_ex.dest;
  assign o_mem_memRead   = r_mem.memRead;
  assign o_mem_memWrite  = r_mem.memWrite;
  assign o_mem_width     = r_mem.width;
  assign o_mem_sign_flag = r_mem.sign_flag;
  assign o_mem_regWrite  = r_mem.regWrite;
  assign o_mem_mem2Reg   = r_mem.mem2Reg;
  assign o_mem_dest      = r_mem.dest;
  assign o_wb_regWrite   = r_wb.regWrite;
  assign o_wb_mem2Reg    = r_wb.mem2Reg;
  assign o_wb_dest       = r_wb.dest;

endmodule

// File: tb/tb_ctrl_pipe_carrier.sv
// Directed bench for ctrl_pipe_carrier: reset, load-use stall, $zero writes,
// flush, halt and JAL destination, each with hand-computed expectations.
module tb_ctrl_pipe_carrier;
  logic       clk = 1'b0;
  logic       i_reset, i_halt, i_flush;
  logic       i_id_jump, i_id_branch, i_id_regDst, i_id_mem2Reg, i_id_regWrite;
  logic       i_id_memRead, i_id_memWrite, i_id_sign_flag, i_id_immediate;
  logic [1:0] i_id_aluSrc, i_id_aluOp, i_id_width;
  logic [4:0] i_id_rs, i_id_rt, i_id_rd;
  logic       o_stall;
  logic       o_ex_jump, o_ex_branch, o_ex_immediate;
  logic [1:0] o_ex_aluSrc, o_ex_aluOp;
  logic [4:0] o_ex_dest, o_mem_dest, o_wb_dest;
  logic       o_mem_memRead, o_mem_memWrite, o_mem_sign_flag, o_mem_regWrite, o_mem_mem2Reg;
  logic [1:0] o_mem_width;
  logic       o_wb_regWrite, o_wb_mem2Reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_pipe_carrier #(.NB_REG(5), .REG_RA(31)) dut (
    .clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_flush(i_flush),
    .i_id_jump(i_id_jump), .i_id_aluSrc(i_id_aluSrc), .i_id_aluOp(i_id_aluOp),
    .i_id_branch(i_id_branch), .i_id_regDst(i_id_regDst), .i_id_mem2Reg(i_id_mem2Reg),
    .i_id_regWrite(i_id_regWrite), .i_id_memRead(i_id_memRead), .i_id_memWrite(i_id_memWrite),
    .i_id_width(i_id_width), .i_id_sign_flag(i_id_sign_flag), .i_id_immediate(i_id_immediate),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_rd(i_id_rd),
    .o_stall(o_stall),
    .o_ex_jump(o_ex_jump), .o_ex_aluSrc(o_ex_aluSrc), .o_ex_aluOp(o_ex_aluOp),
    .o_ex_branch(o_ex_branch), .o_ex_immediate(o_ex_immediate), .o_ex_dest(o_ex_dest),
    .o_mem_memRead(o_mem_memRead), .o_mem_memWrite(o_mem_memWrite), .o_mem_width(o_mem_width),
    .o_mem_sign_flag(o_mem_sign_flag), .o_mem_regWrite(o_mem_regWrite),
    .o_mem_mem2Reg(o_mem_mem2Reg), .o_mem_dest(o_mem_dest),
    .o_wb_regWrite(o_wb_regWrite), .o_wb_mem2Reg(o_wb_mem2Reg), .o_wb_dest(o_wb_dest)
  );

  logic [11:0] ex_vec;
  logic [30:0] all_vec;
  assign ex_vec  = {o_ex_jump, o_ex_aluSrc, o_ex_aluOp, o_ex_branch, o_ex_immediate, o_ex_dest};
  assign all_vec = {ex_vec, o_mem_memRead, o_mem_memWrite, o_mem_width, o_mem_sign_flag,
                    o_mem_regWrite, o_mem_mem2Reg, o_mem_dest,
                    o_wb_regWrite, o_wb_mem2Reg, o_wb_dest};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    i_id_jump = 0; i_id_aluSrc = 0; i_id_aluOp = 0; i_id_branch = 0; i_id_regDst = 0;
    i_id_mem2Reg = 0; i_id_regWrite = 0; i_id_memRead = 0; i_id_memWrite = 0;
    i_id_width = 0; i_id_sign_flag = 0; i_id_immediate = 0;
    i_id_rs = 0; i_id_rt = 0; i_id_rd = 0;
  endtask

  task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    nop();
    i_id_regDst = 1; i_id_regWrite = 1; i_id_aluOp = 2'b10;
    i_id_rs = rs; i_id_rt = rt; i_id_rd = rd;
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
    nop();
    i_id_memRead = 1; i_id_regWrite = 1; i_id_mem2Reg = 1; i_id_aluSrc = 2'b01;
    i_id_immediate = 1; i_id_width = 2'b11; i_id_sign_flag = 1;
    i_id_rs = rs; i_id_rt = rt;
  endtask

  task automatic sw(input logic [4:0] rs, input logic [4:0] rt);
    nop();
    i_id_memWrite = 1; i_id_aluSrc = 2'b01; i_id_immediate = 1; i_id_width = 2'b11;
    i_id_rs = rs; i_id_rt = rt;
  endtask

  initial begin
    i_reset = 0; i_halt = 1; i_flush = 0;
    nop();
    #2;
    chk("reset_outputs_zero", 32'(all_vec), 0);
    chk("reset_stall_low_with_halt", 32'(o_stall), 0);
    i_halt = 0;
    @(posedge clk); #1;
    i_reset = 1;

    // T1: ADD through the pipe, then async reset mid-stream
    add(1, 2, 3);
    step();
    chk("t1_ex_dest", 32'(o_ex_dest), 3);
    chk("t1_ex_aluOp", 32'(o_ex_aluOp), 2);
    step();
    chk("t1_mem_dest_rw", 32'({o_mem_regWrite, o_mem_dest}), 32'h23);
    step();
    chk("t1_wb_dest_rw", 32'({o_wb_regWrite, o_wb_dest}), 32'h23);
    #2 i_reset = 0;
    #1;
    chk("t1_async_reset_zero", 32'(all_vec), 0);
    nop();
    step();
    chk("t1_reset_held_zero", 32'(all_vec), 0);
    i_reset = 1;
    step(); chk("t1_no_wb_pulse_a", 32'(o_wb_regWrite), 0);
    step(); chk("t1_no_wb_pulse_b", 32'(o_wb_regWrite), 0);
    step(); chk("t1_no_wb_pulse_c", 32'(o_wb_regWrite), 0);

    // T2: load-use stall on rt=8
    lw(1, 8);
    step();
    chk("t2_ex_lw_dest", 32'(o_ex_dest), 8);
    add(8, 2, 4);
    #1;
    chk("t2_stall_high", 32'(o_stall), 1);
    step();
    chk("t2_ex_bubble", 32'(ex_vec), 0);
    chk("t2_mem_lw", 32'({o_mem_memRead, o_mem_regWrite, o_mem_dest}), 32'h68);
    chk("t2_stall_one_cycle", 32'(o_stall), 0);
    step();
    chk("t2_add_ex_dest", 32'(o_ex_dest), 4);
    chk("t2_add_ex_aluOp", 32'(o_ex_aluOp), 2);
    nop();
    step(); step(); step();

    // T3: load to $zero never stalls and never writes
    lw(1, 0);
    step();
    add(0, 2, 5);
    #1;
    chk("t3_no_stall", 32'(o_stall), 0);
    step();
    chk("t3_mem_rw_off", 32'({o_mem_memRead, o_mem_regWrite}), 32'h2);
    chk("t3_ex_add_dest", 32'(o_ex_dest), 5);
    nop();
    step();
    chk("t3_wb_rw_off", 32'(o_wb_regWrite), 0);
    chk("t3_mem_add", 32'({o_mem_regWrite, o_mem_dest}), 32'h25);
    step(); step();

    // T4: flush squashes BEQ while SW moves on
    sw(1, 6);
    step();
    nop(); i_id_branch = 1; i_id_aluOp = 2'b01; i_id_rs = 1; i_id_rt = 2;
    i_flush = 1;
    step();
    i_flush = 0;
    chk("t4_ex_bubble", 32'(ex_vec), 0);
    chk("t4_mem_sw", 32'({o_mem_memWrite, o_mem_memRead, o_mem_regWrite}), 32'h4);

    // flush coinciding with load-use: one bubble, stall still from hazard
    lw(1, 9);
    step();
    add(9, 1, 7);
    i_flush = 1;
    #1;
    chk("t4_flush_haz_stall", 32'(o_stall), 1);
    step();
    i_flush = 0;
    chk("t4_flush_haz_bubble", 32'(ex_vec), 0);
    chk("t4_flush_haz_mem", 32'({o_mem_memRead, o_mem_dest}), 32'h29);
    step();
    chk("t4_flush_haz_resume", 32'(o_ex_dest), 7);
    nop();
    step(); step(); step();

    // T5: halt for 3 cycles
    add(1, 2, 10);
    step();
    add(1, 2, 11);
    step();
    add(1, 2, 12);
    i_halt = 1;
    #1;
    chk("t5_stall_halt", 32'(o_stall), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_hold_dests", 32'({o_ex_dest, o_mem_dest, o_wb_dest}), {17'd0, 5'd11, 5'd10, 5'd0});
      chk("t5_hold_stall", 32'(o_stall), 1);
    end
    i_halt = 0;
    step();
    chk("t5_resume_dests", 32'({o_ex_dest, o_mem_dest, o_wb_dest}), {17'd0, 5'd12, 5'd11, 5'd10});
    chk("t5_resume_wb_rw", 32'(o_wb_regWrite), 1);
    nop();
    step();
    chk("t5_resume_wb_next", 32'(o_wb_dest), 11);
    step(); step();

    // T6: JAL targets the link register
    nop(); i_id_jump = 1; i_id_regWrite = 1; i_id_rt = 4; i_id_rd = 6;
    step();
    chk("t6_ex_jal", 32'({o_ex_jump, o_ex_dest}), 32'h3F);
    nop();
    step();
    chk("t6_mem_jal", 32'({o_mem_regWrite, o_mem_dest}), 32'h3F);
    step();
    chk("t6_wb_jal", 32'({o_wb_regWrite, o_wb_dest}), 32'h3F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
